branch_predict_ctrl: RTL
========================

Name: branch_predict_ctrl

Overview:
- Controls next-PC sequencing for the 5-stage pipeline.
- Holds a pattern history table (PHT) of 2-bit saturating counters. Predicts branches in ID and resolves them in EX.
- Drives the next-PC mux select and the IF/ID and ID/EX flush signals. Also keeps branch and mispredict statistics counters.

Parameters:
- IDX_W, 4, PHT index width; table has 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- INIT_CTR, 2'b11, reset value of every PHT counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- STAT_W, 32, width of statistics counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- stall_i  in  1  load-use stall from hazard unit; holds IF and ID.
- branch_id_i  in  1  ID instruction is a conditional branch.
- pc_id_i  in  32  PC of ID instruction.
- taken_ex_i  in  1  actual branch outcome from EX compare; valid only while an EX branch is tracked.
- predict_o  out  1  prediction for ID branch (combinational).
- next_pc_sel_o  out  2  0: pc+4, 1: ID branch target, 2: EX branch target, 3: EX branch pc+4.
- flush_if_id_o  out  1  squash IF/ID register next edge.
- flush_id_ex_o  out  1  squash ID/EX register next edge.
- wrong_predict_o  out  1  EX branch mispredicted (combinational).
- ex_pc_plus4_o  out  32  registered EX-branch pc+4, for mux input 3.
- branch_cnt_o  out  STAT_W  resolved branches.
- mispred_cnt_o  out  STAT_W  mispredicted branches.

Behaviour:
- Reset (async, rst_i=0) sets:
  - all PHT entries to INIT_CTR;
  - EX tracking valid (ex_v) to 0;
  - ex_pred, ex_idx and ex_pc_plus4_o to 0;
  - both stat counters to 0.
  - With ex_v=0, combinational outputs read 0, including next_pc_sel_o=0.
  - Reset asserted mid-operation drops any tracked EX branch; no PHT update occurs.
- Prediction: predict_o = branch_id_i & PHT[pc_id_i[IDX_W+1:2]][1]. It reads the registered table, with no same-cycle bypass of an EX update.
- EX tracking register, updated each rising edge:
  - When stall_i=1 or wrong_predict_o=1, ex_v<=0 (bubble, or the ID branch is squashed).
  - Otherwise: ex_v<=branch_id_i, ex_pred<=predict_o, ex_idx<=pc index, ex_pc_plus4_o<=pc_id_i+4.
- wrong_predict_o = ex_v & (ex_pred != taken_ex_i).
- Select priority, highest first:
  - wrong_predict_o: sel=2 if taken_ex_i, else 3.
  - else if predict_o and !stall_i: sel=1.
  - else: sel=0.
- Flushes:
  - flush_if_id_o = wrong_predict_o | (predict_o & !stall_i).
  - flush_id_ex_o = wrong_predict_o.
- PHT update, on an edge with ex_v=1:
  - taken: counter saturating increment (11 stays 11);
  - not taken: counter saturating decrement (00 stays 00).
  - The update applies regardless of stall_i.
- Stats, on an edge with ex_v=1:
  - branch_cnt_o increments;
  - mispred_cnt_o increments if wrong_predict_o;
  - both wrap modulo 2**STAT_W.
- Simultaneous events:
  - EX mispredict with a predicted-taken ID branch: EX recovery wins, and the ID branch is neither redirected nor tracked.
  - EX update and ID lookup to the same index in one cycle: ID sees the old value, and the new value is visible next cycle.
- Latency: prediction same cycle as ID; resolution/recovery one cycle after ID (EX); PHT effect one cycle after EX.

Test Plan:
1. Reset, then branch_id_i=1, pc_id_i=0x40 -> predict_o=1, sel=1, flush_if_id_o=1. Next cycle taken_ex_i=1 -> wrong_predict_o=0, sel=0, branch_cnt_o=1, PHT[0] stays 11.
2. Same branch resolves not-taken three times in a row -> PHT[0] goes 11->10->01, so predict_o=0 from the third lookup. The mispredicts set sel=3 with ex_pc_plus4_o=0x44, flush_id_ex_o=1, and mispred_cnt_o=2.
3. PHT[0]=00, branch resolves taken -> sel=2, both flushes=1, PHT[0]=01. Further not-taken resolutions keep the counter at 00 (saturation).
4. stall_i=1 with branch_id_i=1, predicted taken -> sel=0, flush_if_id_o=0, ex_v=0 next cycle. When the stall releases, the branch is predicted and tracked exactly once (branch_cnt_o +1).
5. EX mispredict while a predicted-taken branch sits in ID at a different index -> sel=2 or 3 (not 1), the ID branch is not tracked, and its PHT entry is unchanged.
6. rst_i pulsed low mid-cycle with ex_v=1 -> outputs clear immediately (sel=0, wrong_predict_o=0), counters are 0, and PHT entries read INIT_CTR after release.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: 2-bit PHT branch prediction, EX resolution, next-PC select and flush control
module branch_predict_ctrl #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] INIT_CTR = 2'b11,
    parameter int         STAT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              branch_id_i,
    input  logic [31:0]       pc_id_i,
    input  logic              taken_ex_i,
    output logic              predict_o,
    output logic [1:0]        next_pc_sel_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              wrong_predict_o,
    output logic [31:0]       ex_pc_plus4_o,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] mispred_cnt_o
);
    localparam int N = 1 << IDX_W;

    logic [1:0]       pht [N];
    logic             ex_v;
    logic             ex_pred;
    logic [IDX_W-1:0] ex_idx;
    logic [IDX_W-1:0] id_idx;
    logic             id_redirect;

    assign id_idx          = pc_id_i[IDX_W+1:2];
    assign predict_o       = branch_id_i & pht[id_idx][1];
    assign wrong_predict_o = ex_v & (ex_pred != taken_ex_i);
    assign id_redirect     = predict_o & ~stall_i;
    assign next_pc_sel_o   = wrong_predict_o ? (taken_ex_i ? 2'd2 : 2'd3) : id_redirect ? 2'd1 : 2'd0;
    assign flush_if_id_o   = wrong_predict_o | id_redirect;
    assign flush_id_ex_o   = wrong_predict_o;

    // Train the resolved branch's counter toward its actual outcome, saturating at both ends
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < N; i++) pht[i] <= INIT_CTR;
        end else if (ex_v) begin
            pht[ex_idx] <= taken_ex_i ? ((pht[ex_idx] == 2'b11) ? 2'b11 : pht[ex_idx] + 2'd1)
                                      : ((pht[ex_idx] == 2'b00) ? 2'b00 : pht[ex_idx] - 2'd1);
        end
    end

    // Carry the ID branch into EX; a stall inserts a bubble and a mispredict squashes the ID branch
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_v          <= 1'b0;
            ex_pred       <= 1'b0;
            ex_idx        <= '0;
            ex_pc_plus4_o <= '0;
        end else if (stall_i || wrong_predict_o) begin
            ex_v <= 1'b0;
        end else begin
            ex_v          <= branch_id_i;
            ex_pred       <= predict_o;
            ex_idx        <= id_idx;
            ex_pc_plus4_o <= pc_id_i + 32'd4;
        end
    end

    // Count every resolved branch and the mispredicted subset, wrapping naturally
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else if (ex_v) begin
            branch_cnt_o  <= branch_cnt_o + 1'b1;
            mispred_cnt_o <= mispred_cnt_o + {{(STAT_W-1){1'b0}}, wrong_predict_o};
        end
    end
endmodule
